// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash slave: opcodes, frame state encoding
// and the JEDEC ID byte selector.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDID  = 8'h9F;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ,
        WRITE,
        ID,
        IGNORE
    } state_t;

    // Byte idx of the 3-byte ID, MSB byte first; idx 3 and beyond read as 0xFF.
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = id[23:16];
            2'd1:    b = id[15:8];
            2'd2:    b = id[7:0];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_slave_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus edge pulses.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   cs, clk, mosi_    raw SPI pins
//   cs_s              synchronized chip select (active low)
//   cs_fall           one-cycle pulse when synchronized cs goes high->low
//   clk_rise/clk_fall one-cycle pulses on synchronized SPI clock edges
//   mosi_s            synchronized mosi_, aligned with clk_rise
module spi_pin_sync (
    input  logic clock,
    input  logic reset,
    input  logic cs,
    input  logic clk,
    input  logic mosi_,
    output logic cs_s,
    output logic cs_fall,
    output logic clk_rise,
    output logic clk_fall,
    output logic mosi_s
);

    logic cs_p0, cs_p1, cs_p2;
    logic clk_p0, clk_p1, clk_p2;
    logic mosi_p0, mosi_p1;

    // The cs chain resets low so that a cs held low across reset never looks
    // like a fresh falling edge: a new frame needs a real high-to-low.
    always_ff @(posedge clock) begin
        if (reset) begin
            cs_p0  <= 1'b0;
            cs_p1  <= 1'b0;
            cs_p2  <= 1'b0;
            clk_p0 <= 1'b0;
            clk_p1 <= 1'b0;
            clk_p2 <= 1'b0;
        end else begin
            cs_p0  <= cs;
            cs_p1  <= cs_p0;
            cs_p2  <= cs_p1;
            clk_p0 <= clk;
            clk_p1 <= clk_p0;
            clk_p2 <= clk_p1;
        end
    end

    always_ff @(posedge clock) begin
        mosi_p0 <= mosi_;
        mosi_p1 <= mosi_p0;
    end

    assign cs_s     = cs_p1;
    assign cs_fall  = cs_p2 & ~cs_p1;
    assign clk_rise = clk_p1 & ~clk_p2;
    assign clk_fall = ~clk_p1 & clk_p2;
    assign mosi_s   = mosi_p1;

endmodule

// File: rtl/spi_flash_slave.sv
// SPI mode-0 slave emulating a small serial flash with READ (0x03),
// WRITE (0x02) and READ ID (0x9F) against an internal byte memory.
// The SPI pins are oversampled by the system clock (>= 4x SPI clk).
// Ports:
//   clock   system clock
//   reset   synchronous active-high reset (memory contents are kept)
//   cs      chip select, active low
//   clk     SPI clock, mode 0
//   mosi_   serial data in, MSB first
//   miso_   serial data out, MSB first; high when not sending data
module spi_flash_slave
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
    parameter string       INIT_FILE  = ""
) (
    input  logic clock,
    input  logic reset,
    input  logic cs,
    input  logic clk,
    input  logic mosi_,
    output logic miso_
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic cs_s, cs_fall, clk_rise, clk_fall, mosi_s;

    spi_pin_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .cs       (cs),
        .clk      (clk),
        .mosi_    (mosi_),
        .cs_s     (cs_s),
        .cs_fall  (cs_fall),
        .clk_rise (clk_rise),
        .clk_fall (clk_fall),
        .mosi_s   (mosi_s)
    );

    state_t                  state, state_next;
    logic [2:0]              bit_cnt;
    logic [4:0]              addr_cnt;
    logic [6:0]              rx_shift;
    logic [7:0]              tx_shift;
    logic [7:0]              opcode;
    logic [1:0]              id_idx;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [7:0]              mem [0:DEPTH-1];

    logic [7:0] rx_byte;
    logic       byte_end;
    logic       bit_active;
    logic [7:0] load_byte;
    logic [7:0] tx_byte;
    logic       wr_en;

    // Power-up image: erased flash (0xFF).
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
    end

    // bit_active: a clock edge that belongs to the current frame; cs high
    // and a frame start both take priority over any edge in the same cycle.
    always_comb begin
        rx_byte    = {rx_shift, mosi_s};
        bit_active = ~cs_s & ~cs_fall;
        byte_end   = bit_active & clk_rise & (bit_cnt == 3'd7);
        load_byte  = (state == READ) ? mem[addr] : id_byte(JEDEC_ID, id_idx);
        // bit_cnt is 0 on the fall that starts each outgoing byte.
        tx_byte    = (bit_cnt == 3'd0) ? load_byte : tx_shift;
        wr_en      = byte_end & (state == WRITE);
    end

    always_comb begin
        state_next = state;
        if (cs_s) begin
            state_next = IDLE;
        end else if (cs_fall) begin
            state_next = CMD;
        end else if (clk_rise) begin
            case (state)
                CMD: begin
                    if (bit_cnt == 3'd7) begin
                        case (rx_byte)
                            CMD_READ, CMD_WRITE: state_next = ADDR;
                            CMD_RDID:            state_next = ID;
                            default:             state_next = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (addr_cnt == 5'd23)
                        state_next = (opcode == CMD_READ) ? READ : WRITE;
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            addr_cnt <= 5'd0;
            rx_shift <= 7'd0;
            tx_shift <= 8'd0;
            opcode   <= 8'd0;
            id_idx   <= 2'd0;
            addr     <= '0;
            miso_    <= 1'b1;
        end else if (cs_s) begin
            bit_cnt <= 3'd0;
            miso_   <= 1'b1;
        end else if (cs_fall) begin
            bit_cnt  <= 3'd0;
            addr_cnt <= 5'd0;
            id_idx   <= 2'd0;
            miso_    <= 1'b1;
        end else begin
            if (clk_rise && state != IDLE) begin
                rx_shift <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                case (state)
                    CMD: begin
                        if (bit_cnt == 3'd7) opcode <= rx_byte;
                    end
                    ADDR: begin
                        // Shifting through an ADDR_WIDTH register keeps only
                        // the low address bits of the 24-bit field.
                        addr     <= {addr[ADDR_WIDTH-2:0], mosi_s};
                        addr_cnt <= addr_cnt + 5'd1;
                    end
                    READ, WRITE: begin
                        if (bit_cnt == 3'd7) addr <= addr + ADDR_WIDTH'(1);
                    end
                    ID: begin
                        if (bit_cnt == 3'd7 && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
            if (clk_fall) begin
                if (state == READ || state == ID) begin
                    miso_    <= tx_byte[7];
                    tx_shift <= {tx_byte[6:0], 1'b1};
                end else begin
                    miso_ <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && wr_en) mem[addr] <= rx_byte;
    end

endmodule

// File: tb/tb_spi_flash_slave.sv
module tb_spi_flash_slave;

    localparam int HALF  = 4;
    localparam int DEPTH = 1024;

    typedef logic [7:0] bytes_t [$];
    typedef struct {
        string name;
        int    val;
    } exp_t;

    logic clock = 1'b0;
    logic reset, cs, sclk, mosi, miso;

    always #5 clock = ~clock;

    spi_flash_slave #(
        .ADDR_WIDTH (10),
        .JEDEC_ID   (24'hEF4018),
        .INIT_FILE  ("")
    ) dut (
        .clock (clock),
        .reset (reset),
        .cs    (cs),
        .clk   (sclk),
        .mosi_ (mosi),
        .miso_ (miso)
    );

    logic [7:0] model_mem [0:DEPTH-1];
    exp_t exp_q[$];
    int   obs_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: pairs every observed value with the oldest expectation.
    initial begin
        exp_t e;
        int   o;
        forever begin
            @(posedge clock);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%02h, nothing expected", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o != e.val) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%02h, expected 0x%02h", e.name, o, e.val);
                    end
                end
            end
        end
    end

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            mosi = tx[7-k];
            repeat (HALF) @(negedge clock);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clock);
            sclk = 1'b0;
        end
    endtask

    task automatic xchg(input logic [7:0] tx, input logic [7:0] e, input string name);
        logic [7:0] rx;
        exp_q.push_back('{name, int'(e)});
        xfer(tx, 8, rx);
        obs_q.push_back(int'(rx));
    endtask

    task automatic check_level(input string name, input logic e);
        exp_q.push_back('{name, int'(e)});
        obs_q.push_back(int'(miso));
    endtask

    task automatic cs_begin();
        @(negedge clock);
        cs = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge clock);
        cs = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic send_addr(input int a, input string name);
        logic [23:0] a24;
        a24 = a[23:0];
        xchg(a24[23:16], 8'hFF, name);
        xchg(a24[15:8],  8'hFF, name);
        xchg(a24[7:0],   8'hFF, name);
    endtask

    task automatic frame_write(input int a, input bytes_t d);
        cs_begin();
        xchg(8'h02, 8'hFF, "wr_cmd_miso");
        send_addr(a, "wr_addr_miso");
        foreach (d[k]) begin
            xchg(d[k], 8'hFF, "wr_data_miso");
            model_mem[(a + k) % DEPTH] = d[k];
        end
        cs_end();
    endtask

    task automatic frame_read(input int a, input int n, input string name);
        cs_begin();
        xchg(8'h03, 8'hFF, "rd_cmd_miso");
        send_addr(a, "rd_addr_miso");
        for (int k = 0; k < n; k++)
            xchg(8'($urandom), model_mem[(a + k) % DEPTH], name);
        cs_end();
    endtask

    task automatic frame_id(input int extra);
        logic [7:0] id_ref [4];
        id_ref = '{8'hEF, 8'h40, 8'h18, 8'hFF};
        cs_begin();
        xchg(8'h9F, 8'hFF, "id_cmd_miso");
        for (int k = 0; k < 4 + extra; k++)
            xchg(8'($urandom), (k < 4) ? id_ref[k] : 8'hFF, "id_byte");
        cs_end();
    endtask

    initial begin
        bytes_t     d;
        logic [7:0] rx;
        int         a, n;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hFF;
        reset = 1'b1;
        cs    = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_level("reset_miso", 1'b1);

        // cs pulse without clocks: nothing happens
        cs_begin();
        repeat (6) @(negedge clock);
        check_level("cs_noclk_low_miso", 1'b1);
        cs_end();
        check_level("cs_noclk_high_miso", 1'b1);

        frame_id(0);

        d = {8'hA5, 8'h3C};
        frame_write(32'h000010, d);
        frame_read(32'h000010, 2, "rd_0x10");

        // wrap from the top address to 0
        d = {8'h11, 8'h22};
        frame_write(32'h0003FF, d);
        frame_read(32'h0003FF, 2, "rd_wrap");
        frame_read(32'h000000, 1, "rd_addr0");

        // partial data byte is dropped
        cs_begin();
        xchg(8'h02, 8'hFF, "pw_cmd_miso");
        send_addr(32'h000020, "pw_addr_miso");
        xfer(8'h00, 5, rx);
        cs_end();
        frame_read(32'h000020, 1, "rd_partial");
        frame_id(1);

        // unknown opcode
        cs_begin();
        xchg(8'h55, 8'hFF, "unk_cmd_miso");
        xchg(8'h00, 8'hFF, "unk_miso");
        xchg(8'h00, 8'hFF, "unk_miso");
        cs_end();
        frame_read(32'h000010, 2, "rd_after_unk");

        // reset in mid-frame: later bits without a new cs fall are ignored
        cs_begin();
        xfer(8'h9F, 4, rx);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        xchg(8'h02, 8'hFF, "rst_ign_miso");
        xchg(8'h00, 8'hFF, "rst_ign_miso");
        xchg(8'h00, 8'hFF, "rst_ign_miso");
        xchg(8'h30, 8'hFF, "rst_ign_miso");
        xchg(8'h77, 8'hFF, "rst_ign_miso");
        cs_end();
        frame_read(32'h000030, 1, "rd_after_rst");
        frame_id(0);

        // random traffic; upper address bits are random and must be ignored
        for (int it = 0; it < 24; it++) begin
            a = int'($urandom & 32'h00FF_FFFF);
            n = int'($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 0) begin
                d = {};
                for (int k = 0; k < n; k++) d.push_back(8'($urandom));
                frame_write(a, d);
            end else begin
                frame_read(a, n, "rd_rand");
            end
        end
        frame_read(32'h0003FE, 4, "rd_wrap_final");

        repeat (20) @(negedge clock);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no output, expected 0x%02h", e.name, e.val);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
